// File: rtl/imm_encoder.sv
// Two-stage RISC-V immediate encoder: range-checks an immediate for its format and
// scatters its bits into an instruction template, behind valid/ready handshakes.
module imm_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_imm_type,
    input  logic [31:0]      in_tmpl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned DATA_LEN       = 32;
    localparam int unsigned INSN_LEN       = 32;
    localparam int unsigned IMM_TYPE_WIDTH = 3;

    typedef enum logic [1:0] {
        ImmI = 2'd0,
        ImmS = 2'd1,
        ImmU = 2'd2,
        ImmJ = 2'd3
    } fmt_e;

    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = 3'd0;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = 3'd1;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = 3'd2;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = 3'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // S1 state
    logic                s1_valid;
    logic [DATA_LEN-1:0] s1_imm;
    fmt_e                s1_fmt;
    logic [INSN_LEN-1:0] s1_tmpl;
    logic                s1_err;

    logic                s2_adv;
    logic                s1_adv;
    logic                accept;
    fmt_e                in_fmt;
    logic                in_err;
    logic [INSN_LEN-1:0] packed_inst;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !flush && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    // Unlisted type codes fold onto the I format.
    always_comb begin
        in_fmt = ImmI;
        unique case (in_imm_type)
            IMM_I:   in_fmt = ImmI;
            IMM_S:   in_fmt = ImmS;
            IMM_U:   in_fmt = ImmU;
            IMM_J:   in_fmt = ImmJ;
            default: in_fmt = ImmI;
        endcase
    end

    always_comb begin
        in_err = 1'b0;
        unique case (in_fmt)
            ImmI, ImmS: in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            ImmU:       in_err = |in_imm[11:0];
            ImmJ:       in_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
            default:    in_err = 1'b0;
        endcase
    end

    always_comb begin
        packed_inst = s1_tmpl;
        unique case (s1_fmt)
            ImmI: packed_inst = {s1_imm[11:0], s1_tmpl[19:0]};
            ImmS: packed_inst = {s1_imm[11:5], s1_tmpl[24:12], s1_imm[4:0], s1_tmpl[6:0]};
            ImmU: packed_inst = {s1_imm[31:12], s1_tmpl[11:0]};
            ImmJ: packed_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                 s1_tmpl[11:0]};
            default: packed_inst = s1_tmpl;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_imm    <= '0;
            s1_fmt    <= ImmI;
            s1_tmpl   <= '0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_inst <= packed_inst;
                    out_err  <= s1_err;
                    if (s1_err && err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_imm   <= in_imm;
                s1_fmt   <= in_fmt;
                s1_tmpl  <= in_tmpl;
                s1_err   <= in_err;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule
